// File: rtl/shift_add_mult_8bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and default operand/counter widths.
package shift_add_mult_8bit_pkg;

    localparam int DEF_N_BITS = 8;
    localparam int DEF_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_8bit.sv
// 8-bit ripple-carry adder used as the multiplier's add stage.
// Carry chains bit by bit from carry_in to carry_out.
module ripple_carry_8bit (
    output logic       carry_out,
    output logic [7:0] sum,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       carry_in
);

    logic [8:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign carry_out = c[8];

endmodule

// File: rtl/shift_add_mult_8bit.sv
// Sequential 8x8 unsigned multiplier: one add/shift step per clock.
// Product {A,Q} is valid while done is high and held until next start.
module shift_add_mult_8bit
    import shift_add_mult_8bit_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_BITS-1:0]     multiplicand,
    input  logic [N_BITS-1:0]     multiplier,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    state_t state;
    state_t next_state;

    logic [N_BITS-1:0] m_reg;
    logic [N_BITS-1:0] a_reg;
    logic [N_BITS-1:0] q_reg;
    logic              c_reg;
    logic [CNT_W-1:0]  count;

    logic [N_BITS-1:0] addend;
    logic [N_BITS-1:0] sum;
    logic              cout;
    logic              unused_carry;

    // Partial product is M when the current multiplier bit is set.
    assign addend = q_reg[0] ? m_reg : '0;

    ripple_carry_8bit u_add (
        .carry_out (cout),
        .sum       (sum),
        .A         (a_reg),
        .B         (addend),
        .carry_in  (1'b0)
    );

    // After the combined add+shift, C always ends up cleared.
    assign unused_carry = c_reg;

    assign product = {a_reg, q_reg};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture and add/shift datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        c_reg <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    c_reg <= 1'b0;
                    a_reg <= {cout, sum[N_BITS-1:1]};
                    q_reg <= {sum[0], q_reg[N_BITS-1:1]};
                    count <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_8bit.sv
// Self-checking bench for the shift-add multiplier.
// Random and directed operands are checked against plain multiplication.
module tb_shift_add_mult_8bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp;
    int n_err;

    shift_add_mult_8bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // Issue one operation; returns product at done and edges from acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int edges,
                          output bit ok);
        int wait_cyc;
        ok = 1'b0;
        edges = 0;
        prod = 'x;
        wait_cyc = 0;
        @(negedge clk);
        while (!ready && wait_cyc < 30) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!ready) return;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                prod = product;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        start = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=100", {ready, busy, done});
        end
        n_cmp++;
        if (product !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_product got=%h want=0000", product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] p;
        int e;
        bit ok;
        run_op(8'd13, 8'd11, p, e, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_timeout no done seen");
            return;
        end
        n_cmp++;
        if (p !== ref_mul(8'd13, 8'd11)) begin
            n_err++;
            $display("FAIL basic_product got=%h want=%h", p, ref_mul(8'd13, 8'd11));
        end
        n_cmp++;
        if (e !== 9) begin
            n_err++;
            $display("FAIL basic_latency got=%0d want=9", e);
        end
        @(negedge clk);
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL basic_after_flags got=%b want=100", {ready, busy, done});
        end
        n_cmp++;
        if (product !== 16'h008F) begin
            n_err++;
            $display("FAIL basic_hold got=%h want=008f", product);
        end
    endtask

    task automatic test_corners;
        logic [7:0] av [6];
        logic [7:0] bv [6];
        logic [15:0] p;
        int e;
        bit ok;
        av = '{8'd255, 8'd0,   8'd200, 8'd1,   8'd128, 8'd255};
        bv = '{8'd255, 8'd200, 8'd0,   8'd173, 8'd2,   8'd1};
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], bv[i], p, e, ok);
            n_cmp++;
            if (!ok || p !== ref_mul(av[i], bv[i])) begin
                n_err++;
                $display("FAIL corner_%0d %0d*%0d got=%h want=%h ok=%0d",
                         i, av[i], bv[i], p, ref_mul(av[i], bv[i]), ok);
            end
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        int seen_at;
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        seen_at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (seen_at < 0) begin
                    seen_at = k;
                    n_cmp++;
                    if (product !== 16'h003F) begin
                        n_err++;
                        $display("FAIL ignore_product got=%h want=003f", product);
                    end
                    multiplicand = 8'd3;
                    multiplier   = 8'd3;
                    start        = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL ignore_done_count got=%0d want=1", dones);
        end
        n_cmp++;
        if (product !== 16'h003F || !ready) begin
            n_err++;
            $display("FAIL ignore_hold got=%h ready=%b want=003f/1", product, ready);
        end
    endtask

    task automatic test_abort;
        logic [15:0] p;
        int e;
        bit ok;
        int dones;
        @(negedge clk);
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, busy, done} !== 3'b100 || product !== 16'h0000) begin
            n_err++;
            $display("FAIL abort_state flags=%b prod=%h want=100/0000",
                     {ready, busy, done}, product);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort_no_done got=%0d want=0", dones);
        end
        run_op(8'd100, 8'd100, p, e, ok);
        n_cmp++;
        if (!ok || p !== 16'h2710) begin
            n_err++;
            $display("FAIL abort_rerun got=%h want=2710 ok=%0d", p, ok);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_q [$];
        logic [15:0] want;
        logic [7:0]  a;
        logic [7:0]  b;
        int got;
        int last_done;
        bit prev_done;
        got = 0;
        last_done = -1;
        prev_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 600 && got < 50; cyc++) begin
            if (done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected done at cycle %0d", cyc);
                end else begin
                    want = exp_q.pop_front();
                    if (product !== want) begin
                        n_err++;
                        $display("FAIL b2b_product #%0d got=%h want=%h", got, product, want);
                    end
                end
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc - last_done !== 10) begin
                        n_err++;
                        $display("FAIL b2b_spacing got=%0d want=10", cyc - last_done);
                    end
                end
                if (prev_done) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b2b_double_done got=1 want=0");
                end
                last_done = cyc;
                got++;
            end
            prev_done = done;
            a = 8'($urandom);
            b = 8'($urandom);
            multiplicand = a;
            multiplier   = b;
            if (ready && got + exp_q.size() < 50) begin
                exp_q.push_back(ref_mul(a, b));
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (got !== 50) begin
            n_err++;
            $display("FAIL b2b_count got=%0d want=50", got);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
